// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MIPS multiply/divide controller owning HI/LO with fixed-latency busy window
// Results are computed at the start edge and held pending until the window closes.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [2:0]  MDUOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        HiLoSelE,
  input  logic        UseMDUD,
  output logic        BusyE,
  output logic        StallMDU,
  output logic [31:0] MDUOutE,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {Idle, Run} stateT;

  stateT            state;
  logic [CntW-1:0]  cnt;
  logic [31:0]      hiP, loP;
  logic             noCommit;
  logic             isLong;
  logic [63:0]      prodS, prodU;
  logic [31:0]      nextHi, nextLo;

  assign isLong   = (MDUOpE >= 3'd1) && (MDUOpE <= 3'd4);
  assign StallMDU = UseMDUD & (BusyE | (StartE & isLong));
  assign MDUOutE  = HiLoSelE ? HI : LO;

  assign prodS = $signed({{32{SrcAE[31]}}, SrcAE}) * $signed({{32{SrcBE[31]}}, SrcBE});
  assign prodU = {32'd0, SrcAE} * {32'd0, SrcBE};

  always_comb begin
    nextHi = '0;
    nextLo = '0;
    case (MDUOpE)
      3'd1: {nextHi, nextLo} = prodS;
      3'd2: {nextHi, nextLo} = prodU;
      3'd3: begin
        // Most-negative / -1 overflows the signed quotient; pin the architectural result.
        if (SrcBE == 32'd0) begin
          nextHi = '0;
          nextLo = '0;
        end else if (SrcAE == 32'h8000_0000 && SrcBE == 32'hFFFF_FFFF) begin
          nextLo = 32'h8000_0000;
          nextHi = '0;
        end else begin
          nextLo = $signed(SrcAE) / $signed(SrcBE);
          nextHi = $signed(SrcAE) % $signed(SrcBE);
        end
      end
      3'd4: begin
        if (SrcBE != 32'd0) begin
          nextLo = SrcAE / SrcBE;
          nextHi = SrcAE % SrcBE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= Idle;
      BusyE    <= 1'b0;
      cnt      <= '0;
      hiP      <= '0;
      loP      <= '0;
      noCommit <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        Idle: begin
          if (StartE) begin
            case (MDUOpE)
              3'd1, 3'd2: begin
                hiP      <= nextHi;
                loP      <= nextLo;
                noCommit <= 1'b0;
                cnt      <= CntW'(MULT_CYCLES);
                BusyE    <= 1'b1;
                state    <= Run;
              end
              3'd3, 3'd4: begin
                hiP      <= nextHi;
                loP      <= nextLo;
                noCommit <= (SrcBE == 32'd0);
                cnt      <= CntW'(DIV_CYCLES);
                BusyE    <= 1'b1;
                state    <= Run;
              end
              3'd5: HI <= SrcAE;
              3'd6: LO <= SrcAE;
              default: ;
            endcase
          end
        end
        Run: begin
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            if (!noCommit) begin
              HI <= hiP;
              LO <= loP;
            end
            BusyE <= 1'b0;
            state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations from the Execute stage, using the already-forwarded operands. It sequences a fixed-latency multi-cycle busy window, owns the HI/LO architectural registers, and raises a stall request to the hazard logic whenever a Decode-stage MDU instruction would collide with an in-flight operation.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- StartE  input  1  operation valid in E this cycle
- MDUOpE  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- SrcAE  input  32  forwarded rs value
- SrcBE  input  32  forwarded rt value
- HiLoSelE  input  1  read select for MDUOutE: 0 LO, 1 HI
- UseMDUD  input  1  D-stage instruction is any MDU op or mfhi/mflo
- BusyE  output  1  registered; operation in flight
- StallMDU  output  1  combinational stall request to hazard unit
- MDUOutE  output  32  combinational HI or LO per HiLoSelE
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- States: IDLE (BusyE=0), RUN (BusyE=1). Down-counter cnt, width sized to DIV_CYCLES.
- IDLE, StartE=1, op 1–4: compute the result at the start edge and hold it in pending hi_p/lo_p; cnt←N (N = MULT_CYCLES or DIV_CYCLES); go to RUN.
- mult: {hi_p,lo_p} = $signed(A)*$signed(B), 64-bit. multu: unsigned 64-bit product.
- div: lo_p = signed quotient, truncated toward zero; hi_p = remainder, sign of dividend. divu: unsigned quotient/remainder.
- Divide by zero (SrcBE=0, op 3/4): full DIV_CYCLES busy window runs, then HI/LO are left unchanged (no commit).
- Overflow case div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- RUN: cnt decrements each edge. At the edge where cnt==1: commit HI←hi_p, LO←lo_p (unless div-by-zero); BusyE←0; return to IDLE.
- mthi/mtlo (op 5/6) in IDLE: HI or LO←SrcAE at that edge. No busy window.
- StartE in RUN is ignored; no state change. The hazard unit guarantees this does not occur.
- StallMDU = UseMDUD & (BusyE | (StartE & MDUOpE∈{1..4})).
- MDUOutE always reflects committed HI/LO. Pending results are never visible.
- Reset: HI=0, LO=0, BusyE=0, cnt=0, pending regs=0, IDLE. A reset asserted during RUN aborts the operation with no commit.

## Timing
- Start edge t0: BusyE=1 from t0+1 through t0+N. BusyE=0 and new HI/LO are visible from the edge t0+N onward, i.e. in the cycle after the last busy cycle.
- mthi/mtlo: new value visible in the cycle after the edge.
- StallMDU is asserted the same cycle StartE is seen, so a dependent mfhi in D waits. It deasserts in the first cycle with BusyE=0, and mfhi then reads the committed value.
- MDUOutE: zero-latency combinational read.

## Test plan
- Signed mult: SrcA=0xFFFFFFFE (-2), SrcB=3 -> BusyE high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: SrcA=0xFFFFFFFF, SrcB=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. HI/LO hold their old values during the busy window.
- Signed div: SrcA=-7 (0xFFFFFFF9), SrcB=2 -> BusyE high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divide by zero with HI=LO=0x12345678 beforehand -> busy 10 cycles, values unchanged.
- Stall: mult start with UseMDUD=1 held -> StallMDU=1 in the start cycle and the following 5 cycles, 0 in the next cycle; MDUOutE with HiLoSelE=0 then equals the new LO.
- mtlo 0xDEADBEEF in IDLE -> LO=0xDEADBEEF next cycle, BusyE stays 0. A StartE with mult during RUN is ignored and the original result commits.
- Reset asserted at busy cycle 3 of a div -> next cycle BusyE=0, HI=LO=0, and no later commit.
